// File: rtl/cpu_types_pkg.sv
// Basic machine types shared by every pipeline stage.
package cpu_types_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/pipeline_pkg.sv
// Pipeline latch layouts and the fetch FSM state type.
package pipeline_pkg;

    import cpu_types_pkg::*;

    localparam word_t INSTR_BYTES = 32'd4;

    // IF/ID latch contents: fetch address, instruction word, fall-through PC.
    typedef struct packed {
        word_t imemaddr;
        word_t instr;
        word_t pc;
    } ifetch_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Sequential PC; wraps naturally from 32'hFFFF_FFFC to 0.
    function automatic word_t pc_plus4(input word_t addr);
        return addr + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetched instruction while the IF/ID latch is stalled.
module fetch_skid
    import pipeline_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  logic    clear,
    input  logic    load,
    input  logic    pop,
    input  ifetch_t load_entry,
    output logic    full,
    output ifetch_t entry
);

    logic    full_q;
    ifetch_t entry_q;

    // clear wins over load so a redirect always discards the captured word.
    always_ff @(posedge CLK) begin
        if (RST) begin
            full_q  <= 1'b0;
            entry_q <= '0;
        end else if (clear) begin
            full_q  <= 1'b0;
        end else if (load) begin
            full_q  <= 1'b1;
            entry_q <= load_entry;
        end else if (pop) begin
            full_q  <= 1'b0;
        end
    end

    assign full  = full_q;
    assign entry = entry_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID latch and FETCH/HOLD/HALTED control.
// Optional one-entry skid buffer enabled by defining FETCH_SKID_EN.
module fetch_stage
    import cpu_types_pkg::*;
    import pipeline_pkg::*;
#(
    parameter word_t PC_INIT = 32'h0000_0000
) (
    input  logic    CLK,
    input  logic    RST,
    input  logic    ihit,
    input  word_t   iload,
    output logic    iREN,
    output word_t   imemaddr,
    input  logic    stall,
    input  logic    redirect,
    input  word_t   redirect_pc,
    input  logic    halt,
    output logic    if_valid,
    output ifetch_t if_out
);

    fetch_state_t state, state_next;
    word_t        pc, pc_next;
    ifetch_t      out_q, out_next;
    logic         valid_q, valid_next;
    ifetch_t      fetched;
    logic         skid_full;

    assign fetched = '{imemaddr: pc, instr: iload, pc: pc_plus4(pc)};

`ifdef FETCH_SKID_EN
    logic    skid_load, skid_pop, skid_clear;
    ifetch_t skid_entry;

    fetch_skid u_skid (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (skid_clear),
        .load       (skid_load),
        .pop        (skid_pop),
        .load_entry (fetched),
        .full       (skid_full),
        .entry      (skid_entry)
    );
`else
    assign skid_full = 1'b0;
`endif

    always_comb begin
        state_next = state;
        pc_next    = pc;
        out_next   = out_q;
        valid_next = valid_q;
`ifdef FETCH_SKID_EN
        skid_load  = 1'b0;
        skid_pop   = 1'b0;
        skid_clear = 1'b0;
`endif
        if (state == HALTED) begin
            valid_next = 1'b0;
        end else if (redirect) begin
            pc_next    = redirect_pc;
            valid_next = 1'b0;
            state_next = FETCH;
`ifdef FETCH_SKID_EN
            skid_clear = 1'b1;
`endif
        end else if (halt) begin
            valid_next = 1'b0;
            state_next = HALTED;
`ifdef FETCH_SKID_EN
            skid_clear = 1'b1;
`endif
        end else if (stall) begin
`ifdef FETCH_SKID_EN
            // Keep fetching into the skid so the next word is ready when stall drops.
            if (!skid_full && ihit) begin
                skid_load = 1'b1;
                pc_next   = pc_plus4(pc);
            end
`else
            state_next = HOLD;
`endif
        end else if (state == HOLD) begin
            // Downstream consumed if_out this edge; nothing new was fetched.
            state_next = FETCH;
            valid_next = 1'b0;
`ifdef FETCH_SKID_EN
        end else if (skid_full) begin
            out_next   = skid_entry;
            valid_next = 1'b1;
            skid_pop   = 1'b1;
`endif
        end else if (ihit) begin
            out_next   = fetched;
            valid_next = 1'b1;
            pc_next    = pc_plus4(pc);
        end else begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= FETCH;
            pc      <= PC_INIT;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            out_q   <= out_next;
            valid_q <= valid_next;
        end
    end

    assign iREN     = (state == FETCH) && !skid_full;
    assign imemaddr = pc;
    assign if_valid = valid_q;
    assign if_out   = out_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage (base build, skid expectations under FETCH_SKID_EN).
module tb_fetch_stage;

    import cpu_types_pkg::*;
    import pipeline_pkg::*;

    logic    CLK = 1'b0;
    logic    RST, ihit, stall, redirect, halt;
    word_t   iload, redirect_pc;
    logic    iREN, if_valid;
    word_t   imemaddr;
    ifetch_t if_out;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.PC_INIT(32'h0000_0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ihit        (ihit),
        .iload       (iload),
        .iREN        (iREN),
        .imemaddr    (imemaddr),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .if_valid    (if_valid),
        .if_out      (if_out)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input word_t a, input word_t i, input word_t p,
                           input logic v);
        chk({tag, ".addr"}, if_out.imemaddr, a);
        chk({tag, ".instr"}, if_out.instr, i);
        chk({tag, ".pc"}, if_out.pc, p);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v});
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
        iload = '0; redirect_pc = '0;
        tick();
        chk("rst.imemaddr", imemaddr, 32'h0);
        chk("rst.iren", {31'd0, iREN}, 32'd1);
        chk_out("rst.out", 32'h0, 32'h0, 32'h0, 1'b0);

        // Back-to-back hits from reset.
        RST = 1'b0; ihit = 1'b1; iload = 32'hC000_0000;
        tick();
        chk_out("seq0", 32'h0, 32'hC000_0000, 32'h4, 1'b1);
        chk("seq0.imemaddr", imemaddr, 32'h4);
        iload = 32'hC000_0004;
        tick();
        chk_out("seq1", 32'h4, 32'hC000_0004, 32'h8, 1'b1);
        chk("seq1.imemaddr", imemaddr, 32'h8);
        iload = 32'hC000_0008;
        tick();
        chk_out("seq2", 32'h8, 32'hC000_0008, 32'hC, 1'b1);
        chk("seq2.imemaddr", imemaddr, 32'hC);
        iload = 32'hC000_000C;
        tick();
        chk_out("seq3", 32'hC, 32'hC000_000C, 32'h10, 1'b1);

        // Memory miss for three cycles at 0x10.
        ihit = 1'b0; iload = 32'hBAD0_BAD0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("miss.imemaddr", imemaddr, 32'h10);
            chk_out("miss.out", 32'hC, 32'hC000_000C, 32'h10, 1'b0);
        end
        ihit = 1'b1; iload = 32'hC000_0010;
        tick();
        chk_out("miss.hit", 32'h10, 32'hC000_0010, 32'h14, 1'b1);
        chk("miss.hit.imemaddr", imemaddr, 32'h14);

        // Two stall cycles with the latch holding 0x10.
        stall = 1'b1; ihit = 1'b1; iload = 32'hC000_0014;
        tick();
        chk_out("stall0", 32'h10, 32'hC000_0010, 32'h14, 1'b1);
        chk("stall0.iren", {31'd0, iREN}, 32'd0);
`ifdef FETCH_SKID_EN
        chk("stall0.imemaddr", imemaddr, 32'h18);
`else
        chk("stall0.imemaddr", imemaddr, 32'h14);
`endif
        ihit = 1'b0;
        tick();
        chk_out("stall1", 32'h10, 32'hC000_0010, 32'h14, 1'b1);
        chk("stall1.iren", {31'd0, iREN}, 32'd0);
        stall = 1'b0;
        tick();
        chk("unstall.iren", {31'd0, iREN}, 32'd1);
`ifdef FETCH_SKID_EN
        chk_out("unstall", 32'h14, 32'hC000_0014, 32'h18, 1'b1);
        chk("unstall.imemaddr", imemaddr, 32'h18);
`else
        chk_out("unstall", 32'h10, 32'hC000_0010, 32'h14, 1'b0);
        chk("unstall.imemaddr", imemaddr, 32'h14);
`endif

        // Redirect beats stall and ihit.
        redirect = 1'b1; redirect_pc = 32'h40; ihit = 1'b1; stall = 1'b1;
        iload = 32'hDEAD_BEEF;
        tick();
        chk("redir.imemaddr", imemaddr, 32'h40);
        chk("redir.valid", {31'd0, if_valid}, 32'd0);
        chk("redir.iren", {31'd0, iREN}, 32'd1);
        redirect = 1'b0; stall = 1'b0; iload = 32'hC000_0040;
        tick();
        chk_out("redir.hit", 32'h40, 32'hC000_0040, 32'h44, 1'b1);
        chk("redir.hit.imemaddr", imemaddr, 32'h44);

        // PC wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; ihit = 1'b0;
        tick();
        chk("wrap.pre", imemaddr, 32'hFFFF_FFFC);
        redirect = 1'b0; ihit = 1'b1; iload = 32'h1234_5678;
        tick();
        chk_out("wrap", 32'hFFFF_FFFC, 32'h1234_5678, 32'h0, 1'b1);
        chk("wrap.imemaddr", imemaddr, 32'h0);

        // Halt together with redirect: redirect wins for one cycle.
        halt = 1'b1; redirect = 1'b1; redirect_pc = 32'h80; iload = 32'hC000_0000;
        tick();
        chk("hr.imemaddr", imemaddr, 32'h80);
        chk("hr.iren", {31'd0, iREN}, 32'd1);
        chk("hr.valid", {31'd0, if_valid}, 32'd0);
        redirect = 1'b0; iload = 32'hC000_0080;
        tick();
        chk("halt.iren", {31'd0, iREN}, 32'd0);
        chk("halt.valid", {31'd0, if_valid}, 32'd0);
        chk("halt.imemaddr", imemaddr, 32'h80);
        halt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halted.iren", {31'd0, iREN}, 32'd0);
            chk("halted.valid", {31'd0, if_valid}, 32'd0);
            chk("halted.imemaddr", imemaddr, 32'h80);
        end

        // Reset overrides halt, redirect and stall.
        RST = 1'b1; halt = 1'b1; redirect = 1'b1; stall = 1'b1;
        tick();
        chk("rst2.imemaddr", imemaddr, 32'h0);
        chk("rst2.iren", {31'd0, iREN}, 32'd1);
        chk_out("rst2.out", 32'h0, 32'h0, 32'h0, 1'b0);
        RST = 1'b0; halt = 1'b0; redirect = 1'b0; stall = 1'b0;
        ihit = 1'b1; iload = 32'hC000_0000;
        tick();
        chk_out("rst2.hit", 32'h0, 32'hC000_0000, 32'h4, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
